// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: defaults, CP0
// ExcCode values and the per-edge action decode used by pipe_stage_reg.
package pipe_pkg;

  localparam int          DATA_W_DEF     = 32;
  localparam int          EXC_W_DEF      = 5;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

  // CP0 ExcCode values; INT shares 0 with NONE because CP0 takes interrupts itself.
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_REQ,
    ACT_FLUSH,
    ACT_HOLD,
    ACT_BUBBLE,
    ACT_LOAD
  } act_e;

  // Fixed priority: reset > req > flush > stall > bubble > load.
  function automatic act_e pick_action(input logic reset, input logic req,
                                       input logic flush, input logic stall,
                                       input logic bubble);
    if (reset)       return ACT_RESET;
    else if (req)    return ACT_REQ;
    else if (flush)  return ACT_FLUSH;
    else if (stall)  return ACT_HOLD;
    else if (bubble) return ACT_BUBBLE;
    else             return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Datapath bundle between two pipeline stages: upstream fields in, registered
// fields out. The stage register itself uses the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 6,
  parameter int EXC_W      = 5
);
  logic                         in_valid;
  logic [DATA_W-1:0]            in_pc;
  logic [DATA_W-1:0]            in_instr;
  logic                         in_bd;
  logic [EXC_W-1:0]             in_exccode;
  logic [EXC_W-1:0]             local_exccode;
  logic [NUM_FIELDS*DATA_W-1:0] in_payload;

  logic                         out_valid;
  logic [DATA_W-1:0]            out_pc;
  logic [DATA_W-1:0]            out_instr;
  logic                         out_bd;
  logic [EXC_W-1:0]             out_exccode;
  logic [NUM_FIELDS*DATA_W-1:0] out_payload;

  modport master (
    output in_valid, in_pc, in_instr, in_bd, in_exccode, local_exccode, in_payload,
    input  out_valid, out_pc, out_instr, out_bd, out_exccode, out_payload
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_bd, in_exccode, local_exccode, in_payload,
    output out_valid, out_pc, out_instr, out_bd, out_exccode, out_payload
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Free-running event counter with enable; wraps modulo 2^CNT_W, cleared only
// by the synchronous reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)   count <= '0;
    else if (en) count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with req/flush/stall/bubble control.
// Optional stall/bubble performance counters under PIPE_REG_PERF_CNT_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = DATA_W_DEF,
  parameter int                 NUM_FIELDS = 6,
  parameter logic [DATA_W-1:0]  EXC_VECTOR = EXC_VECTOR_DEF,
  parameter int                 EXC_W      = EXC_W_DEF,
  parameter int                 CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              stall,
  input  logic              bubble,
  pipe_stage_reg_if.slave   stg,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic                         valid_q;
  logic [DATA_W-1:0]            pc_q;
  logic [DATA_W-1:0]            instr_q;
  logic                         bd_q;
  logic [EXC_W-1:0]             exc_q;
  logic [NUM_FIELDS*DATA_W-1:0] payload_q;

  act_e             act;
  logic [EXC_W-1:0] merged_exc;

  // NOTE: every combinational output gets a value on every path, so no latch is inferred.
  always_comb begin
    act        = pick_action(reset, req, flush, stall, bubble);
    merged_exc = (stg.in_exccode != '0) ? stg.in_exccode : stg.local_exccode;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    unique case (act)
      ACT_RESET, ACT_FLUSH: begin
        valid_q   <= 1'b0;
        pc_q      <= '0;
        instr_q   <= '0;
        bd_q      <= 1'b0;
        exc_q     <= '0;
        payload_q <= '0;
      end
      ACT_REQ: begin
        valid_q   <= 1'b0;
        pc_q      <= EXC_VECTOR;
        instr_q   <= '0;
        bd_q      <= 1'b0;
        exc_q     <= '0;
        payload_q <= '0;
      end
      ACT_HOLD: begin
      end
      // PC and BD survive a bubble so CP0 can still form a precise EPC.
      ACT_BUBBLE: begin
        valid_q   <= 1'b0;
        pc_q      <= stg.in_pc;
        instr_q   <= '0;
        bd_q      <= stg.in_bd;
        exc_q     <= '0;
        payload_q <= '0;
      end
      default: begin
        valid_q   <= stg.in_valid;
        pc_q      <= stg.in_pc;
        instr_q   <= stg.in_instr;
        bd_q      <= stg.in_bd;
        exc_q     <= merged_exc;
        payload_q <= stg.in_payload;
      end
    endcase
  end

  assign stg.out_valid   = valid_q;
  assign stg.out_pc      = pc_q;
  assign stg.out_instr   = instr_q;
  assign stg.out_bd      = bd_q;
  assign stg.out_exccode = exc_q;
  assign stg.out_payload = payload_q;

`ifdef PIPE_REG_PERF_CNT_EN
  logic stall_en;
  logic bubble_en;

  always_comb begin
    stall_en  = (act == ACT_HOLD);
    bubble_en = (act == ACT_BUBBLE);
  end

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_en),
    .count (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (bubble_en),
    .count (bubble_cnt)
  );
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised self-checking bench for pipe_stage_reg against a rule-level
// reference model; counter checks follow PIPE_REG_PERF_CNT_EN.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW  = 32;
  localparam int NF  = 6;
  localparam int EW  = 5;
  localparam int CW  = 32;
  localparam logic [DW-1:0] VEC = 32'h0000_4180;

  logic clk = 1'b0;
  logic reset, req, flush, stall, bubble;
  logic [CW-1:0] stall_cnt, bubble_cnt;

  pipe_stage_reg_if #(.DATA_W(DW), .NUM_FIELDS(NF), .EXC_W(EW)) stg_if ();

  pipe_stage_reg #(
    .DATA_W(DW), .NUM_FIELDS(NF), .EXC_VECTOR(VEC), .EXC_W(EW), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .flush      (flush),
    .stall      (stall),
    .bubble     (bubble),
    .stg        (stg_if),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic             e_valid, e_bd;
  logic [DW-1:0]    e_pc, e_instr;
  logic [EW-1:0]    e_exc;
  logic [NF*DW-1:0] e_pay;
  logic [CW-1:0]    e_scnt = '0, e_bcnt = '0;

  task automatic clear_model();
    e_valid = 0; e_bd = 0; e_pc = '0; e_instr = '0; e_exc = '0; e_pay = '0;
  endtask

  // Apply the current inputs for one edge, predict, then compare.
  task automatic step();
    if (reset) begin
      clear_model(); e_scnt = '0; e_bcnt = '0;
    end else if (req) begin
      clear_model(); e_pc = VEC;
    end else if (flush) begin
      clear_model();
    end else if (stall) begin
      e_scnt = e_scnt + 1;
    end else if (bubble) begin
      e_valid = 0; e_instr = '0; e_pay = '0; e_exc = '0;
      e_pc = stg_if.in_pc; e_bd = stg_if.in_bd; e_bcnt = e_bcnt + 1;
    end else begin
      e_valid = stg_if.in_valid; e_pc = stg_if.in_pc; e_instr = stg_if.in_instr;
      e_bd = stg_if.in_bd; e_pay = stg_if.in_payload;
      e_exc = (stg_if.in_exccode != 0) ? stg_if.in_exccode : stg_if.local_exccode;
    end
    @(posedge clk);
    #1;
    check("valid",   256'(stg_if.out_valid),   256'(e_valid));
    check("pc",      256'(stg_if.out_pc),      256'(e_pc));
    check("instr",   256'(stg_if.out_instr),   256'(e_instr));
    check("bd",      256'(stg_if.out_bd),      256'(e_bd));
    check("exccode", 256'(stg_if.out_exccode), 256'(e_exc));
    check("payload", 256'(stg_if.out_payload), 256'(e_pay));
`ifdef PIPE_REG_PERF_CNT_EN
    check("stall_cnt",  256'(stall_cnt),  256'(e_scnt));
    check("bubble_cnt", 256'(bubble_cnt), 256'(e_bcnt));
`else
    check("stall_cnt",  256'(stall_cnt),  256'(0));
    check("bubble_cnt", 256'(bubble_cnt), 256'(0));
`endif
  endtask

  task automatic ctl(input logic r, input logic q, input logic f, input logic s, input logic b);
    reset = r; req = q; flush = f; stall = s; bubble = b;
  endtask

  function automatic logic [EW-1:0] rand_exc();
    logic [EW-1:0] tbl [8] = '{EXC_NONE, EXC_NONE, EXC_NONE, EXC_ADEL,
                               EXC_ADES, EXC_RI, EXC_OV, EXC_NONE};
    return tbl[$urandom_range(7)];
  endfunction

  task automatic rand_data();
    stg_if.in_valid      = 1'($urandom);
    stg_if.in_pc         = $urandom;
    stg_if.in_instr      = $urandom;
    stg_if.in_bd         = 1'($urandom);
    stg_if.in_exccode    = rand_exc();
    stg_if.local_exccode = rand_exc();
    for (int k = 0; k < NF; k++) stg_if.in_payload[k*DW +: DW] = $urandom;
  endtask

  initial begin
    clear_model();
    // Reset with every input nonzero
    ctl(1, 1, 1, 1, 1);
    stg_if.in_valid = 1; stg_if.in_pc = '1; stg_if.in_instr = '1; stg_if.in_bd = 1;
    stg_if.in_exccode = '1; stg_if.local_exccode = '1; stg_if.in_payload = '1;
    step();
    check("reset_pc_zero", 256'(stg_if.out_pc), 256'(0));

    // Plain load
    ctl(0, 0, 0, 0, 0);
    stg_if.in_pc = 32'h3000; stg_if.in_instr = 32'h2402_0005; stg_if.in_valid = 1;
    stg_if.in_bd = 0; stg_if.in_exccode = 0; stg_if.local_exccode = 0;
    stg_if.in_payload = '0; stg_if.in_payload[2*DW +: DW] = 32'hDEAD_BEEF;
    step();
    check("load_field2", 256'(stg_if.out_payload[2*DW +: DW]), 256'(32'hDEAD_BEEF));

    // Three stall cycles while inputs move
    ctl(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin rand_data(); step(); end
    check("stall_pc_frozen", 256'(stg_if.out_pc), 256'(32'h3000));

    // Bubble keeps PC/BD
    ctl(0, 0, 0, 0, 1);
    rand_data(); stg_if.in_pc = 32'h3008; stg_if.in_bd = 1;
    step();
    check("bubble_pc", 256'(stg_if.out_pc), 256'(32'h3008));

    // Request dominates stall and flush
    ctl(0, 1, 1, 1, 0);
    rand_data();
    step();
    check("req_vector", 256'(stg_if.out_pc), 256'(32'h0000_4180));

    // Oldest exception wins, then local one
    ctl(0, 0, 0, 0, 0);
    rand_data(); stg_if.in_exccode = EXC_ADEL; stg_if.local_exccode = EXC_OV;
    step();
    check("exc_oldest", 256'(stg_if.out_exccode), 256'(5'd4));
    stg_if.in_exccode = EXC_NONE; stg_if.local_exccode = EXC_OV;
    step();
    check("exc_local", 256'(stg_if.out_exccode), 256'(5'd12));

    // Randomised control and data
    for (int i = 0; i < 400; i++) begin
      ctl($urandom_range(99) < 2, $urandom_range(99) < 6, $urandom_range(99) < 6,
          $urandom_range(99) < 25, $urandom_range(99) < 20);
      rand_data();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
